instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch (IF) stage of the pipelined MIPS core, directly upstream of the instruction memory. It owns the program counter and drives the memory's address, chip-select and read-enable. It captures the memory's combinational 32-bit read data into the IF/ID pipeline register. It applies stall, flush and branch/jump redirect requests from downstream stages, and can halt fetch on a BREAK instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `IM_ADDR_W`, default 12: instruction-memory byte-address width.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hazard unit hold request; the PC and IF/ID hold.
- `flush`  in  1: inserts a bubble into IF/ID.
- `redirect_valid`  in  1: a taken branch or jump from a later stage.
- `redirect_pc`  in  32: redirect target; bits [1:0] are ignored and forced to 0.
- `im_addr`  out  IM_ADDR_W: equals `pc[IM_ADDR_W-1:0]`.
- `im_cs`, `im_rd`  out  1 each: memory select and read enable; both are driven identically.
- `im_rdata`  in  32: the memory's read data, valid in the same cycle it is addressed.
- `if_id_valid`  out  1: the IF/ID register holds a real instruction.
- `if_id_instr`  out  32: the fetched instruction.
- `if_id_pc_plus4`  out  32: PC of the fetched instruction plus 4.
- `pc`  out  32: current fetch PC.
- `halted`  out  1: fetch is stopped on a BREAK.
- `fetch_count`  out  32: number of instructions accepted into IF/ID; wraps modulo 2^32.

## Operation
- The FSM has three states: BOOT, RUN, HALTED.
  - BOOT lasts exactly one cycle after reset release, then moves to RUN unconditionally.
  - `im_cs` and `im_rd` are 1 only in RUN.
- Per-edge priority in RUN is redirect > stall > flush > advance.
  - **Redirect:** `pc <= {redirect_pc[31:2],2'b00}`; the IF/ID valid bit is cleared and the instruction and PC fields hold. This applies even when `stall` is asserted.
  - **Stall** (no redirect): the PC and all IF/ID fields hold, including the valid bit. `flush` is ignored in this case.
  - **Flush** (no redirect, no stall): the IF/ID valid bit is cleared and the PC holds.
  - **Advance:** `if_id_instr <= im_rdata`, `if_id_pc_plus4 <= pc+4`, valid <= 1, `pc <= pc+4`, and `fetch_count` increments.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0. `im_addr` simply truncates the PC, so PC 4092 + 4 addresses memory byte 0.
- BREAK is defined as `im_rdata[31:26]==0 && im_rdata[5:0]==6'h0D`.
- HALTED state:
  - `im_cs` and `im_rd` are 0 and `halted` is 1.
  - The PC holds at the address of the BREAK.
  - Each non-stalled edge loads a bubble into IF/ID (valid <= 0).
  - A redirect returns the FSM to RUN with the PC set to the target and `halted` cleared. This covers the case where the BREAK was on a wrong path.
  - Stall and flush behave as in RUN.
- BOOT state: stall, flush and redirect are ignored, and IF/ID stays invalid.

## Timing
- Reset values: `pc`=RESET_PC, state BOOT, `if_id_valid`=0, `if_id_instr`=0, `if_id_pc_plus4`=0, `halted`=0, `fetch_count`=0, `im_cs`=`im_rd`=0.
- Assertion of `reset_n` forces these values immediately, including mid-stall or mid-halt.
- Latency:
  - First edge after release: BOOT to RUN.
  - Second edge: the instruction at RESET_PC is in IF/ID.
  - Steady state: one instruction per cycle.
- The memory is read combinationally; `im_rdata` is sampled at the same edge that advances the PC.
- Redirect penalty: one bubble. The target instruction is in IF/ID on the second edge after redirect.
- `halted` rises on the same edge that captures the BREAK.

## Configuration
- `IF_HALT_ON_BREAK_EN` defined: BREAK detection and the HALTED state are compiled in, as described above.
- Not defined: BREAK is fetched as an ordinary instruction, HALTED is unreachable, and `halted` is tied to 0.

## Structure
- The shared package `mips_pkg` holds:
  - the FSM state enum `if_state_t` (BOOT, RUN, HALTED);
  - constants `OP_SPECIAL`=6'h00 and `FUNCT_BREAK`=6'h0D;
  - `INSTR_W`=32.
- One sub-module, `if_id_reg`, holds the IF/ID pipeline register with stall-hold and flush-bubble controls. It is instantiated once.

## Test plan
- **Reset and boot:** memory holds 0x20080005 at byte 0, RESET_PC=0, release reset → edge 1: `im_cs`=1 → edge 2: `if_id_instr`=0x20080005, `if_id_pc_plus4`=4, `pc`=4, `fetch_count`=1.
- **Stall vs. redirect:** hold `stall` 3 cycles at pc=8 → PC and IF/ID unchanged, `fetch_count` frozen. Then `stall`=1 with `redirect_valid`=1 and `redirect_pc`=0x43 → `pc`=0x40 and `if_id_valid`=0 next edge.
- **Flush:** `flush`=1 for one cycle at pc=0x10 → `if_id_valid`=0, `pc` stays 0x10, next edge fetches from 0x10.
- **Wrap:** redirect to 0xFFC with IM_ADDR_W=12 → next `im_addr`=0, `pc`=0x1000, `if_id_pc_plus4`=0x1000.
- **BREAK** (macro on): 0x0000000D at 0x20 → `halted`=1, `pc`=0x20, `im_cs`=0, following IF/ID bubbles. Redirect to 0x100 → RUN, `halted`=0. With macro off, fetch continues to 0x24.
- **Reset mid-halt:** assert `reset_n`=0 asynchronously while HALTED → all outputs take reset values before the next clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, instruction field constants and a BREAK
// decoder helper.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] FUNCT_BREAK = 6'h0D;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } if_state_t;

    function automatic logic is_break(input logic [INSTR_W-1:0] instr);
        return (instr[31:26] == OP_SPECIAL) && (instr[5:0] == FUNCT_BREAK);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory port between the fetch stage (master) and the instruction memory (slave).
interface instruction_fetch_if #(
    parameter int unsigned IM_ADDR_W = 12
);
    logic [IM_ADDR_W-1:0] im_addr;
    logic                 im_cs;
    logic                 im_rd;
    logic [31:0]          im_rdata;

    modport master (
        output im_addr,
        output im_cs,
        output im_rd,
        input  im_rdata
    );

    modport slave (
        input  im_addr,
        input  im_cs,
        input  im_rd,
        output im_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. hold freezes every field; bubble clears only the valid bit;
// load captures a new instruction. Priority is hold > bubble > load.
module if_id_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hold,
    input  logic               bubble,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [31:0]        pc_plus4_in,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc_plus4
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        pc_plus4_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_plus4_q <= '0;
        end else if (!hold) begin
            if (bubble) begin
                // Payload fields are kept; only the valid bit marks the slot empty.
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q    <= 1'b1;
                instr_q    <= instr_in;
                pc_plus4_q <= pc_plus4_in;
            end
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: PC, instruction-memory drive and IF/ID capture.
// Define IF_HALT_ON_BREAK_EN to stop fetch on a BREAK instruction (HALTED state).
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IM_ADDR_W = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    instruction_fetch_if.master im,
    output logic                if_id_valid,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [31:0]         if_id_pc_plus4,
    output logic [31:0]         pc,
    output logic                halted,
    output logic [31:0]         fetch_count
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        reg_hold, reg_bubble, reg_load;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        reg_hold   = 1'b0;
        reg_bubble = 1'b0;
        reg_load   = 1'b0;

        unique case (state_q)
            BOOT: begin
                // Control inputs are ignored; IF/ID stays as reset left it.
                state_d  = RUN;
                reg_hold = 1'b1;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    reg_bubble = 1'b1;
                end else if (stall) begin
                    reg_hold = 1'b1;
                end else if (flush) begin
                    reg_bubble = 1'b1;
                end else begin
                    reg_load = 1'b1;
                    count_d  = count_q + 32'd1;
`ifdef IF_HALT_ON_BREAK_EN
                    // PC parks on the BREAK so a later redirect resumes cleanly.
                    if (is_break(im.im_rdata)) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_plus4;
                    end
`else
                    pc_d = pc_plus4;
`endif
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    reg_bubble = 1'b1;
                    state_d    = RUN;
                end else if (stall) begin
                    reg_hold = 1'b1;
                end else begin
                    reg_bubble = 1'b1;
                end
            end
            default: begin
                state_d  = BOOT;
                reg_hold = 1'b1;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .reset_n     (reset_n),
        .hold        (reg_hold),
        .bubble      (reg_bubble),
        .load        (reg_load),
        .instr_in    (im.im_rdata),
        .pc_plus4_in (pc_plus4),
        .valid       (if_id_valid),
        .instr       (if_id_instr),
        .pc_plus4    (if_id_pc_plus4)
    );

    assign im.im_addr  = pc_q[IM_ADDR_W-1:0];
    assign im.im_cs    = (state_q == RUN);
    assign im.im_rd    = (state_q == RUN);
    assign pc          = pc_q;
    assign fetch_count = count_q;

`ifdef IF_HALT_ON_BREAK_EN
    assign halted = (state_q == HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized stall, flush
// and redirect traffic compared every cycle against a behavioural model of the fetch stage.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc_plus4, pc, fetch_count;
    logic        halted;

    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: mode 0 = boot, 1 = run, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    always #5 clk = ~clk;

    instruction_fetch_if #(.IM_ADDR_W(12)) im_bus ();

    assign im_bus.im_rdata = mem[im_bus.im_addr[11:2]];

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .IM_ADDR_W (12)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im             (im_bus),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .pc             (pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic brk(input logic [31:0] w);
        return (w[31:26] == 6'd0) && (w[5:0] == 6'h0D);
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] word;
        word = mem[m_pc[11:2]];
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (redirect_valid) begin
            m_pc    = redirect_pc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_mode  = 1;
        end else if (stall) begin
            // everything holds
        end else if (m_mode == 2 || flush) begin
            m_valid = 1'b0;
        end else begin
            m_instr = word;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
`ifdef IF_HALT_ON_BREAK_EN
            if (brk(word)) m_mode = 2;
            else m_pc = m_pc + 32'd4;
`else
            m_pc = m_pc + 32'd4;
`endif
        end
    endtask

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("im_addr", {20'd0, im_bus.im_addr}, {20'd0, m_pc[11:0]});
        chk("im_cs", {31'd0, im_bus.im_cs}, {31'd0, m_mode == 1});
        chk("im_rd", {31'd0, im_bus.im_rd}, {31'd0, m_mode == 1});
        chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    // One clock: model advances with the DUT edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic s, input logic f, input logic rv, input logic [31:0] rpc);
        stall          = s;
        flush          = f;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 1024; i++) mem[i] = $urandom | 32'h8000_0000;
        mem[0] = 32'h2008_0005;
        mem[8] = 32'h0000_000D;
        model_reset();

        // Reset and boot
        @(negedge clk);
        compare_all();
        chk("rst_im_cs", {31'd0, im_bus.im_cs}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("boot_im_cs", {31'd0, im_bus.im_cs}, 32'd1);
        chk("boot_pc", pc, 32'h0);
        tick();
        chk("first_instr", if_id_instr, 32'h2008_0005);
        chk("first_pc4", if_id_pc_plus4, 32'h4);
        chk("first_pc", pc, 32'h4);
        chk("first_count", fetch_count, 32'd1);
        chk("model_first_pc", m_pc, 32'h4);

        // Stall at pc=8, then stall together with redirect
        tick();
        chk("pre_stall_pc", pc, 32'h8);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 32'h8);
            chk("stall_count", fetch_count, 32'd2);
            chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
            chk("stall_pc4", if_id_pc_plus4, 32'h8);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h43);
        tick();
        chk("redir_stall_pc", pc, 32'h40);
        chk("redir_stall_valid", {31'd0, if_id_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("redir_target_pc4", if_id_pc_plus4, 32'h44);
        chk("redir_target_instr", if_id_instr, mem[16]);

        // Flush at pc=0x10
        drive(1'b0, 1'b0, 1'b1, 32'h10);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
        chk("flush_pc", pc, 32'h10);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("after_flush_pc4", if_id_pc_plus4, 32'h14);
        chk("after_flush_instr", if_id_instr, mem[4]);

        // Address wrap at 4 KiB and 32-bit PC wrap
        drive(1'b0, 1'b0, 1'b1, 32'hFFC);
        tick();
        chk("wrap_addr_pre", {20'd0, im_bus.im_addr}, 32'hFFC);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_im_addr", {20'd0, im_bus.im_addr}, 32'h0);
        chk("wrap_pc", pc, 32'h1000);
        chk("wrap_pc4", if_id_pc_plus4, 32'h1000);
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        tick();
        chk("top_pc", pc, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("pc32_wrap", pc, 32'h0);
        chk("pc4_32_wrap", if_id_pc_plus4, 32'h0);

        // BREAK at 0x20
        drive(1'b0, 1'b0, 1'b1, 32'h20);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("brk_instr", if_id_instr, 32'h0000_000D);
`ifdef IF_HALT_ON_BREAK_EN
        chk("brk_halted", {31'd0, halted}, 32'd1);
        chk("brk_pc", pc, 32'h20);
        chk("brk_im_cs", {31'd0, im_bus.im_cs}, 32'd0);
        tick();
        chk("brk_bubble", {31'd0, if_id_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        chk("brk_resume_halted", {31'd0, halted}, 32'd0);
        chk("brk_resume_pc", pc, 32'h100);
        chk("brk_resume_cs", {31'd0, im_bus.im_cs}, 32'd1);
`else
        chk("brk_pc_cont", pc, 32'h24);
        chk("brk_no_halt", {31'd0, halted}, 32'd0);
`endif

        // Asynchronous reset while halted (or running) and stalled
        drive(1'b0, 1'b0, 1'b1, 32'h20);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("async_pc", pc, 32'h0);
        chk("async_halted", {31'd0, halted}, 32'd0);
        chk("async_count", fetch_count, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("reboot_instr", if_id_instr, 32'h2008_0005);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 6) == 0, ($urandom % 8) == 0, ($urandom % 10) == 0,
                  (($urandom % 4) == 0) ? $urandom : ($urandom & 32'h1FFF));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
